// File: rtl/reg_bank_sb.sv
// reg_bank_sb
// -----------------------------------------------------------------------------
// Register bank with a per-register busy scoreboard for the multicycle datapath.
// DEPTH registers of W bits, two combinational read ports, one write port.
// Optional write-through bypass (BYPASS) and optional hardwired-zero r0
// (ZERO_R0). The busy scoreboard lets the controller stall on registers whose
// producing instruction has not yet written back.
//
// Ports:
//   Clock        in   1   rising-edge clock
//   Reset        in   1   asynchronous, active-low; clears registers and busy bits
//   WriteEnable  in   1   write WriteData to WriteAddr at the next rising edge
//   WriteAddr    in   AW  write address
//   WriteData    in   W   write data
//   ReadAddrA/B  in   AW  read port addresses
//   ReadDataA/B  out  W   read port data (combinational)
//   SetBusy      in   1   mark SetBusyAddr busy at the next rising edge
//   SetBusyAddr  in   AW  register to mark busy
//   BusyA/B      out  1   busy bit of ReadAddrA/B (combinational)
//   AnyBusy      out  1   OR of all busy bits (registered state)
// -----------------------------------------------------------------------------
module reg_bank_sb #(
    parameter int W       = 8,
    parameter int DEPTH   = 16,
    parameter bit BYPASS  = 1'b1,
    parameter bit ZERO_R0 = 1'b0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          WriteEnable,
    input  logic [AW-1:0] WriteAddr,
    input  logic [W-1:0]  WriteData,
    input  logic [AW-1:0] ReadAddrA,
    input  logic [AW-1:0] ReadAddrB,
    output logic [W-1:0]  ReadDataA,
    output logic [W-1:0]  ReadDataB,
    input  logic          SetBusy,
    input  logic [AW-1:0] SetBusyAddr,
    output logic          BusyA,
    output logic          BusyB,
    output logic          AnyBusy
);

    logic [W-1:0]     regs_q [DEPTH];
    logic [W-1:0]     regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Effective write / set after masking out r0 when it is hardwired to zero.
    logic wr_en;
    logic set_en;

    // Bypass qualifiers per read port.
    logic fwd_a;
    logic fwd_b;
    logic set_same_wr;

    always_comb begin
        wr_en  = WriteEnable && !(ZERO_R0 && (WriteAddr == '0));
        set_en = SetBusy && !(ZERO_R0 && (SetBusyAddr == '0));
    end

    // Next-state for the register array.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WriteAddr] = WriteData;
        end
    end

    // Next-state for the scoreboard: a set beats a simultaneous write-back,
    // because the set stands for a newer producer than the one retiring.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (set_en && (SetBusyAddr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_en && (WriteAddr == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_R0) begin
            busy_d[0] = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports. The Reset gate keeps the bypass path from leaking WriteData
    // while the bank is held in reset.
    always_comb begin
        fwd_a       = BYPASS && wr_en && (ReadAddrA == WriteAddr);
        fwd_b       = BYPASS && wr_en && (ReadAddrB == WriteAddr);
        set_same_wr = set_en && (SetBusyAddr == WriteAddr);

        ReadDataA = fwd_a ? WriteData : regs_q[ReadAddrA];
        ReadDataB = fwd_b ? WriteData : regs_q[ReadAddrB];
        if (ZERO_R0 && (ReadAddrA == '0)) begin
            ReadDataA = '0;
        end
        if (ZERO_R0 && (ReadAddrB == '0)) begin
            ReadDataB = '0;
        end

        // A forwarded write also retires the busy bit it would clear, unless a
        // new producer is being issued to the same register in this cycle;
        // SetBusy can only hold the bit, never raise it combinationally.
        BusyA = busy_q[ReadAddrA] && !(fwd_a && !set_same_wr);
        BusyB = busy_q[ReadAddrB] && !(fwd_b && !set_same_wr);

        if (!Reset) begin
            ReadDataA = '0;
            ReadDataB = '0;
            BusyA     = 1'b0;
            BusyB     = 1'b0;
        end
    end

    assign AnyBusy = Reset && (|busy_q);

endmodule

// File: tb/tb_reg_bank_sb.sv
// Testbench for reg_bank_sb. Three instances share one stimulus stream:
//   dut0: BYPASS=0, ZERO_R0=0
//   dut1: BYPASS=1, ZERO_R0=0
//   dutz: BYPASS=1, ZERO_R0=1
// Inputs change at the falling edge; outputs are sampled 1ns later, well
// before the next rising edge that commits the cycle.
module tb_reg_bank_sb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] raa;
    logic [3:0] rab;
    logic       sb;
    logic [3:0] sba;

    logic [7:0] rda0, rdb0, rda1, rdb1, rdaz, rdbz;
    logic       ba0, bb0, any0, ba1, bb1, any1, baz, bbz, anyz;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    reg_bank_sb #(.W(8), .DEPTH(16), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut0 (
        .Clock(clk), .Reset(rst_n), .WriteEnable(we), .WriteAddr(waddr),
        .WriteData(wdata), .ReadAddrA(raa), .ReadAddrB(rab),
        .ReadDataA(rda0), .ReadDataB(rdb0), .SetBusy(sb), .SetBusyAddr(sba),
        .BusyA(ba0), .BusyB(bb0), .AnyBusy(any0)
    );

    reg_bank_sb #(.W(8), .DEPTH(16), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut1 (
        .Clock(clk), .Reset(rst_n), .WriteEnable(we), .WriteAddr(waddr),
        .WriteData(wdata), .ReadAddrA(raa), .ReadAddrB(rab),
        .ReadDataA(rda1), .ReadDataB(rdb1), .SetBusy(sb), .SetBusyAddr(sba),
        .BusyA(ba1), .BusyB(bb1), .AnyBusy(any1)
    );

    reg_bank_sb #(.W(8), .DEPTH(16), .BYPASS(1'b1), .ZERO_R0(1'b1)) dutz (
        .Clock(clk), .Reset(rst_n), .WriteEnable(we), .WriteAddr(waddr),
        .WriteData(wdata), .ReadAddrA(raa), .ReadAddrB(rab),
        .ReadDataA(rdaz), .ReadDataB(rdbz), .SetBusy(sb), .SetBusyAddr(sba),
        .BusyA(baz), .BusyB(bbz), .AnyBusy(anyz)
    );

    task automatic idle();
        we = 1'b0;
        sb = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we = 1'b1; waddr = 4'd3; wdata = 8'hFF; raa = 4'd3; rab = 4'd3;
        sb = 1'b1; sba = 4'd3;
        #1;
        n_chk++; if (rda0 !== 8'h00) begin n_err++; $display("FAIL rst_rda0: got %h exp 00", rda0); end
        n_chk++; if (rda1 !== 8'h00) begin n_err++; $display("FAIL rst_bypass_rda1: got %h exp 00", rda1); end
        n_chk++; if (rdb1 !== 8'h00) begin n_err++; $display("FAIL rst_bypass_rdb1: got %h exp 00", rdb1); end
        n_chk++; if (ba1 !== 1'b0) begin n_err++; $display("FAIL rst_ba1: got %b exp 0", ba1); end
        n_chk++; if (any1 !== 1'b0) begin n_err++; $display("FAIL rst_any1: got %b exp 0", any1); end
        n_chk++; if (anyz !== 1'b0) begin n_err++; $display("FAIL rst_anyz: got %b exp 0", anyz); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        n_chk++; if (rda1 !== 8'h00) begin n_err++; $display("FAIL rst_write_discarded: got %h exp 00", rda1); end
        n_chk++; if (any0 !== 1'b0) begin n_err++; $display("FAIL rst_set_discarded: got %b exp 0", any0); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        we = 1'b1; waddr = 4'd3; wdata = 8'hA5; sb = 1'b1; sba = 4'd5;
        @(negedge clk);
        idle(); raa = 4'd3; rab = 4'd5;
        #1;
        n_chk++; if (rda0 !== 8'hA5) begin n_err++; $display("FAIL mid_pre_r3: got %h exp a5", rda0); end
        n_chk++; if (bb0 !== 1'b1) begin n_err++; $display("FAIL mid_pre_busy5: got %b exp 1", bb0); end
        n_chk++; if (any0 !== 1'b1) begin n_err++; $display("FAIL mid_pre_any: got %b exp 1", any0); end
        #1;
        rst_n = 1'b0; raa = 4'd5; rab = 4'd3;
        #1;
        n_chk++; if (rdb0 !== 8'h00) begin n_err++; $display("FAIL mid_rst_r3: got %h exp 00", rdb0); end
        n_chk++; if (ba0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy5: got %b exp 0", ba0); end
        n_chk++; if (any0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_any: got %b exp 0", any0); end
        we = 1'b1; waddr = 4'd3; wdata = 8'h5A;
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        n_chk++; if (rdb0 !== 8'h00) begin n_err++; $display("FAIL mid_inflight_r3: got %h exp 00", rdb0); end
    endtask

    task automatic test_write_latency();
        @(negedge clk);
        we = 1'b1; waddr = 4'd7; wdata = 8'h3C; raa = 4'd7;
        #1;
        n_chk++; if (rda0 !== 8'h00) begin n_err++; $display("FAIL lat_nobyp_same: got %h exp 00", rda0); end
        n_chk++; if (rda1 !== 8'h3C) begin n_err++; $display("FAIL lat_byp_same: got %h exp 3c", rda1); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (rda0 !== 8'h3C) begin n_err++; $display("FAIL lat_nobyp_next: got %h exp 3c", rda0); end
        n_chk++; if (rda1 !== 8'h3C) begin n_err++; $display("FAIL lat_byp_next: got %h exp 3c", rda1); end
    endtask

    task automatic test_hold();
        @(negedge clk);
        we = 1'b1; waddr = 4'd2; wdata = 8'h11;
        @(negedge clk);
        we = 1'b0; wdata = 8'hFF; waddr = 4'd2; raa = 4'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_chk++; if (rda0 !== 8'h11) begin n_err++; $display("FAIL hold_r2_nobyp[%0d]: got %h exp 11", k, rda0); end
            n_chk++; if (rda1 !== 8'h11) begin n_err++; $display("FAIL hold_r2_byp[%0d]: got %h exp 11", k, rda1); end
            @(negedge clk);
        end
    endtask

    task automatic test_busy();
        @(negedge clk);
        sb = 1'b1; sba = 4'd4; rab = 4'd4;
        #1;
        n_chk++; if (bb0 !== 1'b0) begin n_err++; $display("FAIL busy_n_nocomb0: got %b exp 0", bb0); end
        n_chk++; if (bb1 !== 1'b0) begin n_err++; $display("FAIL busy_n_nocomb1: got %b exp 0", bb1); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (bb0 !== 1'b1) begin n_err++; $display("FAIL busy_n1_b0: got %b exp 1", bb0); end
        n_chk++; if (bb1 !== 1'b1) begin n_err++; $display("FAIL busy_n1_b1: got %b exp 1", bb1); end
        n_chk++; if (any0 !== 1'b1) begin n_err++; $display("FAIL busy_n1_any: got %b exp 1", any0); end
        @(negedge clk);
        #1;
        n_chk++; if (bb0 !== 1'b1) begin n_err++; $display("FAIL busy_n2_b0: got %b exp 1", bb0); end
        @(negedge clk);
        we = 1'b1; waddr = 4'd4; wdata = 8'h55;
        #1;
        n_chk++; if (bb0 !== 1'b1) begin n_err++; $display("FAIL busy_n3_nobyp: got %b exp 1", bb0); end
        n_chk++; if (bb1 !== 1'b0) begin n_err++; $display("FAIL busy_n3_byp: got %b exp 0", bb1); end
        n_chk++; if (rdb1 !== 8'h55) begin n_err++; $display("FAIL busy_n3_byp_data: got %h exp 55", rdb1); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (bb0 !== 1'b0) begin n_err++; $display("FAIL busy_n4_nobyp: got %b exp 0", bb0); end
        n_chk++; if (bb1 !== 1'b0) begin n_err++; $display("FAIL busy_n4_byp: got %b exp 0", bb1); end
        n_chk++; if (rdb0 !== 8'h55) begin n_err++; $display("FAIL busy_n4_r4: got %h exp 55", rdb0); end
        n_chk++; if (any0 !== 1'b0) begin n_err++; $display("FAIL busy_n4_any: got %b exp 0", any0); end
    endtask

    task automatic test_set_and_write();
        @(negedge clk);
        sb = 1'b1; sba = 4'd6; we = 1'b1; waddr = 4'd6; wdata = 8'h77; raa = 4'd6;
        #1;
        n_chk++; if (rda0 !== 8'h00) begin n_err++; $display("FAIL sw_c0_old: got %h exp 00", rda0); end
        n_chk++; if (rda1 !== 8'h77) begin n_err++; $display("FAIL sw_c0_byp: got %h exp 77", rda1); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (rda0 !== 8'h77) begin n_err++; $display("FAIL sw_c1_r6: got %h exp 77", rda0); end
        n_chk++; if (ba0 !== 1'b1) begin n_err++; $display("FAIL sw_c1_busy0: got %b exp 1", ba0); end
        n_chk++; if (ba1 !== 1'b1) begin n_err++; $display("FAIL sw_c1_busy1: got %b exp 1", ba1); end
        n_chk++; if (any0 !== 1'b1) begin n_err++; $display("FAIL sw_c1_any: got %b exp 1", any0); end
        @(negedge clk);
        sb = 1'b1; sba = 4'd6; we = 1'b1; waddr = 4'd6; wdata = 8'h79;
        #1;
        n_chk++; if (ba1 !== 1'b1) begin n_err++; $display("FAIL sw_c2_set_keeps: got %b exp 1", ba1); end
        n_chk++; if (rda1 !== 8'h79) begin n_err++; $display("FAIL sw_c2_byp: got %h exp 79", rda1); end
        @(negedge clk);
        sb = 1'b0; we = 1'b1; waddr = 4'd6; wdata = 8'h78;
        #1;
        n_chk++; if (ba0 !== 1'b1) begin n_err++; $display("FAIL sw_c3_busy0: got %b exp 1", ba0); end
        n_chk++; if (ba1 !== 1'b0) begin n_err++; $display("FAIL sw_c3_busy1: got %b exp 0", ba1); end
        n_chk++; if (rda0 !== 8'h79) begin n_err++; $display("FAIL sw_c3_r6: got %h exp 79", rda0); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (ba0 !== 1'b0) begin n_err++; $display("FAIL sw_c4_busy0: got %b exp 0", ba0); end
        n_chk++; if (any0 !== 1'b0) begin n_err++; $display("FAIL sw_c4_any: got %b exp 0", any0); end
        n_chk++; if (rda0 !== 8'h78) begin n_err++; $display("FAIL sw_c4_r6: got %h exp 78", rda0); end
    endtask

    task automatic test_zero_r0();
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        int         j;
        @(negedge clk);
        we = 1'b1; waddr = 4'd0; wdata = 8'hEE; sb = 1'b1; sba = 4'd0; raa = 4'd0;
        #1;
        n_chk++; if (rdaz !== 8'h00) begin n_err++; $display("FAIL z0_c0_byp: got %h exp 00", rdaz); end
        n_chk++; if (rda1 !== 8'hEE) begin n_err++; $display("FAIL z0_c0_nz_byp: got %h exp ee", rda1); end
        @(negedge clk);
        idle();
        #1;
        n_chk++; if (rdaz !== 8'h00) begin n_err++; $display("FAIL z0_c1_r0: got %h exp 00", rdaz); end
        n_chk++; if (baz !== 1'b0) begin n_err++; $display("FAIL z0_c1_busy: got %b exp 0", baz); end
        n_chk++; if (anyz !== 1'b0) begin n_err++; $display("FAIL z0_c1_any: got %b exp 0", anyz); end
        n_chk++; if (rda0 !== 8'hEE) begin n_err++; $display("FAIL z0_c1_nz_r0: got %h exp ee", rda0); end
        n_chk++; if (ba0 !== 1'b1) begin n_err++; $display("FAIL z0_c1_nz_busy: got %b exp 1", ba0); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            we = 1'b1; waddr = 4'(i); wdata = 8'(i + 1);
        end
        @(negedge clk);
        idle();
        for (int i = 0; i < 16; i++) begin
            j = 15 - i;
            raa = 4'(i); rab = 4'(j);
            #1;
            exp_a = (i == 0) ? 8'h00 : 8'(i + 1);
            exp_b = (j == 0) ? 8'h00 : 8'(j + 1);
            n_chk++; if (rda0 !== 8'(i + 1)) begin n_err++; $display("FAIL sweep_a[%0d]: got %h exp %h", i, rda0, 8'(i + 1)); end
            n_chk++; if (rdb0 !== 8'(j + 1)) begin n_err++; $display("FAIL sweep_b[%0d]: got %h exp %h", j, rdb0, 8'(j + 1)); end
            n_chk++; if (rdaz !== exp_a) begin n_err++; $display("FAIL sweep_za[%0d]: got %h exp %h", i, rdaz, exp_a); end
            n_chk++; if (rdbz !== exp_b) begin n_err++; $display("FAIL sweep_zb[%0d]: got %h exp %h", j, rdbz, exp_b); end
        end
        n_chk++; if (any0 !== 1'b0) begin n_err++; $display("FAIL sweep_any0: got %b exp 0", any0); end
        n_chk++; if (anyz !== 1'b0) begin n_err++; $display("FAIL sweep_anyz: got %b exp 0", anyz); end
    endtask

    initial begin
        rst_n = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0; raa = '0; rab = '0; sb = 1'b0; sba = '0;
        test_reset();
        test_reset_midrun();
        test_write_latency();
        test_hold();
        test_busy();
        test_set_and_write();
        test_zero_r0();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/reg_bank_sb.md
# reg_bank_sb

Parametrised register bank for the multicycle datapath: DEPTH registers of W bits each, with two asynchronous read ports and one write port with write enable. It adds three things a single enabled register lacks:
- an optional write-through bypass;
- an optional hardwired-zero register 0;
- a per-register busy scoreboard, so the controller can stall on registers whose producing instruction has not yet written back.

It sits between the decode stage (read addresses) and the write-back stage (write port).

## Interface
Parameters:
- W, 8, data width of each register (≥1)
- DEPTH, 16, number of registers; power of two, ≥2
- AW, log2(DEPTH), address width (derived, not overridden)
- BYPASS, 1, 1 = write data forwarded combinationally to a read port addressing the register being written
- ZERO_R0, 0, 1 = register 0 always reads 0, ignores writes and busy-set

Ports:
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low; clears all registers and busy bits
- WriteEnable  in  1  write WriteData to register WriteAddr at next rising edge
- WriteAddr  in  AW  write address
- WriteData  in  W  write data
- ReadAddrA  in  AW  read port A address
- ReadAddrB  in  AW  read port B address
- ReadDataA  out  W  read port A data (combinational)
- ReadDataB  out  W  read port B data (combinational)
- SetBusy  in  1  mark register SetBusyAddr busy at next rising edge
- SetBusyAddr  in  AW  register to mark busy
- BusyA  out  1  busy bit of ReadAddrA (combinational)
- BusyB  out  1  busy bit of ReadAddrB (combinational)
- AnyBusy  out  1  OR of all busy bits

## Operation
- Reset low, at any time and asynchronously:
  - every register is 0 and every busy bit is 0;
  - ReadDataA/B read 0 and BusyA/B and AnyBusy read 0 while reset is held;
  - an in-flight write or SetBusy in that cycle is discarded.
- Write: on a rising edge with WriteEnable=1, reg[WriteAddr] <= WriteData. With WriteEnable=0 every register holds.
- Read: ReadDataX = reg[ReadAddrX]. If BYPASS=1, WriteEnable=1 and ReadAddrX==WriteAddr, then ReadDataX = WriteData instead.
- Busy bit update at each rising edge, per register i:
  - SetBusy=1 and SetBusyAddr==i: busy[i] <= 1. Set wins over a simultaneous write to i, because a new producer has been issued.
  - else WriteEnable=1 and WriteAddr==i: busy[i] <= 0. Write-back retires the pending producer.
  - else: hold.
- BusyX = busy[ReadAddrX]. If BYPASS=1 and a write to ReadAddrX occurs this cycle with no SetBusy to the same address, BusyX reads 0, consistent with the forwarded data.
- ZERO_R0=1:
  - ReadDataX=0 whenever ReadAddrX==0, bypass included;
  - busy[0] is constantly 0;
  - writes and SetBusy to address 0 are ignored.
- Writing a register that is not busy is legal and updates it normally.

## Timing
- Write latency:
  - BYPASS=0: new value visible on a read port in the cycle after the write edge.
  - BYPASS=1: visible combinationally in the write cycle, and from the register thereafter.
- SetBusy latency: BusyX reflects the set from the cycle after the edge; no combinational path from SetBusy to BusyX.
- AnyBusy is a registered-state OR: it updates one cycle after the set or clear edge.
- Read ports are fully independent; A and B may address the same register.
- Reset release is synchronous to no edge. The first write is honoured at the first rising edge with Reset high.

## Test plan
1. Reset low mid-run, after writing 0xA5 to r3 and setting busy on r5 -> r3 reads 0x00 and BusyA(addr 5)=0 immediately (before the next edge); AnyBusy=0.
2. Write 0x3C to r7 with BYPASS=0, ReadAddrA=7 in the same cycle -> ReadDataA shows the old value (0x00) in that cycle and 0x3C in the next. With BYPASS=1, ReadDataA=0x3C in the same cycle.
3. WriteEnable=0 with WriteData=0xFF, WriteAddr=2 for 4 cycles -> r2 unchanged at its prior value 0x11.
4. SetBusy r4 at cycle n -> BusyB(addr 4)=1 from n+1. Write r4=0x55 at cycle n+3 -> busy cleared and BusyB=0 from n+4 (BYPASS=0), or already 0 in cycle n+3 (BYPASS=1); r4 reads 0x55.
5. SetBusy r6 and write r6=0x77 on the same edge -> r6=0x77 and busy[6]=1 afterwards.
6. ZERO_R0=1: write 0xEE to r0 and SetBusy r0 -> ReadDataA(addr 0)=0x00, BusyA=0, AnyBusy unchanged. Also sweep all DEPTH=16 addresses, writing i+1 and reading it back on both ports.
